uart_frame_tx: RTL and testbench
================================

# uart_frame_tx

Downstream telemetry stage for the AD-measurement datapath. It takes the decimal (BCD) frequency and peak-to-peak readings that also feed the 7-segment display. On each rising edge of a periodic trigger it snapshots both readings. It formats them into one ASCII text line and shifts the line out on an 8N1 UART pin. It replaces the ad hoc sender with one frame-oriented block that has defined busy/done/drop status.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate; `BAUD_DIV = CLK_FREQ/BAUD` (integer division, 868 at defaults), must be ≥ 2.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `trigger` input 1: frame request; only a rising edge counts; synchronous to `clk`.
- `freq_bcd` input 32: 8 BCD digits of frequency, [31:28] is the most significant digit.
- `peak_bcd` input 32: 8 BCD digits of peak-to-peak, same digit ordering.
- `tx_pin_out` output 1: UART TX line, idle high.
- `busy` output 1: high from snapshot until the last stop bit ends.
- `frame_done` output 1: one-cycle pulse after the final stop bit.
- `dropped` output 1: one-cycle pulse when a trigger edge arrives while `busy`.

## Operation
- Edge detect:
  - `trig_q` is a register of `trigger`, reset value 1. A `trigger` held high through reset therefore does not fire.
  - An edge is `trigger & ~trig_q`.
- Edge while idle:
  - Snapshot `freq_bcd` and `peak_bcd` into internal registers in that same cycle.
  - Assert `busy` from the next cycle.
- Edge while busy:
  - Ignored; pulse `dropped`.
  - Snapshot registers are unchanged.
- Frame, 23 bytes, LSB first: `F` `:` f7..f0 space `P` `:` p7..p0 CR LF.
- Digit encoding:
  - Nibble 0–9 maps to 0x30+n.
  - Nibble 0xA–0xF maps to `-` (0x2D), so the reset value 0xFFFF… prints as dashes.
- Each byte is 10 bits: start 0, 8 data bits, stop 1. Each bit lasts exactly `BAUD_DIV` clocks.
- Bytes are back to back; there are no idle bits inside a frame.
- Frame FSM states:
  - IDLE: wait for an edge.
  - LOAD: select the byte at `byte_idx` and start the serializer.
  - SHIFT: wait for the serializer to finish. Then `byte_idx+1` goes to LOAD, or after the last byte goes to DONE.
  - DONE: pulse `frame_done`, clear `busy`, return to IDLE.
- `byte_idx` is 5 bits and resets to 0 in IDLE.

## Timing
- Reset values: `tx_pin_out`=1, `busy`=0, `frame_done`=0, `dropped`=0. FSM goes to IDLE; bit, baud and byte counters go to 0.
- Reset mid-frame aborts immediately. The line goes high asynchronously and no partial frame resumes after reset.
- Edge at cycle N:
  - `busy`=1 at N+1.
  - Start bit (`tx_pin_out`=0) begins at N+2.
- Frame duration: 23·10·`BAUD_DIV` clocks from the first start bit to the end of the last stop bit (25·10·`BAUD_DIV` with checksum). That is 199,640 clocks at defaults.
- `frame_done` is high for exactly one cycle, directly after the last stop bit period.
- `busy` falls in the same cycle as `frame_done`.
- An edge in the `frame_done` cycle counts as busy and is dropped. An edge in the cycle after it is accepted.
- Input changes after the snapshot have no effect on the frame in flight.

## Configuration
- `UART_FRAME_CHECKSUM_EN` defined:
  - Two uppercase hex ASCII characters are inserted between p0 and CR, giving a 25-byte frame.
  - The checksum is the XOR of all bytes from `F` through p0; the high nibble is sent first.
- Undefined: 23-byte frame with no checksum logic.

## Structure
- Shared package holds:
  - ASCII constants (`F`, `P`, `:`, space, `-`, CR, LF).
  - Frame length constants (23 and 25).
  - FSM state typedef.
- Sub-module `uart_tx_byte`: 8N1 serializer.
  - Inputs: `start`, `data[7:0]`.
  - Outputs: `tx`, `done` (one-cycle pulse at the end of the stop bit).
  - Parameterized by `BAUD_DIV`.
  - Owns the baud counter and bit counter.

## Test plan
Bench uses `CLK_FREQ`=1_000_000 and `BAUD`=100_000, so `BAUD_DIV`=10. A UART monitor samples at mid-bit.
- Single frame: `freq_bcd`=0x00001234, `peak_bcd`=0x00000987, one trigger edge. Required decode is "F:00001234 P:00000987\r\n"; `frame_done` pulses at edge+2+2300 cycles.
- Invalid digits: both inputs 0xFFFFFFFF. Required decode is "F:-------- P:--------\r\n".
- Overlap: a second edge 500 cycles after the first. Required: `dropped` pulses once, only one frame is sent, and changing the inputs mid-frame does not alter the output bytes.
- Reset: assert `rst` 1000 cycles into a frame with `trigger` held high. Required: `tx_pin_out`=1 and `busy`=0 immediately, and no frame after release until a new 0→1 edge.
- Checksum build: both inputs zero. Required decode is "F:00000000 P:00000000" followed by "36\r\n", 25 bytes.
- Back-to-back: edge in the `frame_done` cycle is dropped; edge one cycle later starts a new frame with its start bit 2 cycles after the edge.

Source files
------------

// File: rtl/uart_frame_tx_pkg.sv
// uart_frame_tx_pkg
// Shared definitions for the telemetry frame transmitter: ASCII constants,
// frame lengths, the frame FSM state type and small character helpers.
// No ports. Optional feature macro used by the top: UART_FRAME_CHECKSUM_EN.

package uart_frame_tx_pkg;

  localparam logic [7:0] ASCII_F     = 8'h46;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int FRAME_LEN_BASE = 23;
  localparam int FRAME_LEN_CSUM = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } frame_state_e;

  // Digit k of an 8-digit BCD word, k=0 is the most significant digit.
  function automatic logic [3:0] bcd_digit(input logic [31:0] v, input logic [2:0] k);
    return 4'(v >> {3'd7 - k, 2'b00});
  endfunction

  // Non-decimal nibbles print as '-' so an unset reading shows as dashes.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : ASCII_DASH;
  endfunction

  // Uppercase hex character for one nibble.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// uart_frame_tx_if
// Groups the frame transmitter's request, data and status signals.
//   trigger     : frame request, rising edge counts
//   freq_bcd    : 8 BCD digits of frequency, [31:28] most significant
//   peak_bcd    : 8 BCD digits of peak-to-peak
//   tx_pin_out  : UART TX line, idle high
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after the final stop bit
//   dropped     : one-cycle pulse for a trigger edge refused while busy
// master modport drives requests, slave modport is the transmitter side.

interface uart_frame_tx_if;

  logic        trigger;
  logic [31:0] freq_bcd;
  logic [31:0] peak_bcd;
  logic        tx_pin_out;
  logic        busy;
  logic        frame_done;
  logic        dropped;

  modport master (
    output trigger, freq_bcd, peak_bcd,
    input  tx_pin_out, busy, frame_done, dropped
  );

  modport slave (
    input  trigger, freq_bcd, peak_bcd,
    output tx_pin_out, busy, frame_done, dropped
  );

endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
// 8N1 byte serializer: start bit 0, 8 data bits LSB first, stop bit 1,
// each bit BAUD_DIV clocks long (BAUD_DIV must be at least 2).
//   clk, rst   : clock, asynchronous active-high reset
//   start      : load data and begin a byte (accepted even in the last
//                stop-bit cycle, so bytes can run back to back)
//   data       : byte to send
//   tx         : serial line, idle high
//   done       : pulse in the final clock of the stop bit
//   near_done  : pulse one clock before done, lets the caller issue the
//                next start so it lands exactly when the stop bit ends

module uart_tx_byte #(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       near_done
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_PREV = CW'(BAUD_DIV - 2);

  logic          active_q, active_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          baud_end;

  assign baud_end  = (baud_q == BAUD_LAST);
  assign done      = active_q && (bit_q == 4'd9) && baud_end;
  assign near_done = active_q && (bit_q == 4'd9) && (baud_q == BAUD_PREV);
  assign tx        = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
    end
  end

  // The shift register refills with ones, so after the eighth data bit
  // its LSB is already the stop-bit level.
  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    if (start) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      shreg_d  = data;
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (baud_end) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          tx_d    = shreg_q[0];
          shreg_d = {1'b1, shreg_q[7:1]};
        end
      end else begin
        baud_d = baud_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx
// Snapshots BCD frequency and peak-to-peak readings on a trigger rising
// edge and sends them as one ASCII line "F:dddddddd P:dddddddd\r\n" over
// an 8N1 UART.
//   CLK_FREQ, BAUD : clock rate and line rate, bit time = CLK_FREQ/BAUD
//   clk, rst       : clock, asynchronous active-high reset
//   bus (slave)    : trigger, freq_bcd, peak_bcd in;
//                    tx_pin_out, busy, frame_done, dropped out
// Optional feature: define UART_FRAME_CHECKSUM_EN to append two uppercase
// hex characters (XOR of all bytes from 'F' to the last peak digit)
// before CR LF, giving a 25-byte line.

module uart_frame_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input logic            clk,
  input logic            rst,
  uart_frame_tx_if.slave bus
);

  import uart_frame_tx_pkg::*;

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

  frame_state_e state_q, state_d;
  logic [4:0]   byte_idx_q, byte_idx_d;
  logic         trig_q;
  logic [31:0]  freq_q;
  logic [31:0]  peak_q;
  logic         dropped_q;
  logic         trig_edge;
  logic         ser_start;
  logic         ser_done;
  logic         ser_near_done;
  logic         ser_tx;
  logic [7:0]   frame_byte;
  logic [2:0]   f_sel;
  logic [2:0]   p_sel;

  assign trig_edge = bus.trigger & ~trig_q;

  // trig_q resets high so a trigger already high through reset never fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      trig_q     <= 1'b1;
      freq_q     <= '1;
      peak_q     <= '1;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      trig_q     <= bus.trigger;
      dropped_q  <= trig_edge && (state_q != ST_IDLE);
      if (trig_edge && (state_q == ST_IDLE)) begin
        freq_q <= bus.freq_bcd;
        peak_q <= bus.peak_bcd;
      end
    end
  end

  // Between bytes the next LOAD is entered on near_done, so its start
  // coincides with the last stop-bit clock and bytes run with no gap.
  // The final byte waits for done instead, so DONE follows the stop bit.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    ser_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        byte_idx_d = '0;
        if (trig_edge) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ser_start = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (byte_idx_q == LAST_IDX) begin
          if (ser_done) state_d = ST_DONE;
        end else if (ser_near_done) begin
          byte_idx_d = byte_idx_q + 5'd1;
          state_d    = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = ASCII_F ^ ASCII_COLON ^ ASCII_SPACE ^ ASCII_P ^ ASCII_COLON;
    for (int i = 0; i < 8; i++) begin
      csum = csum ^ bcd_to_ascii(bcd_digit(freq_q, 3'(i)))
                  ^ bcd_to_ascii(bcd_digit(peak_q, 3'(i)));
    end
  end
`endif

  // Byte map: 0 'F', 1 ':', 2-9 freq digits, 10 ' ', 11 'P', 12 ':',
  // 13-20 peak digits, then optional checksum, then CR LF.
  always_comb begin
    frame_byte = ASCII_LF;
    f_sel      = 3'(byte_idx_q - 5'd2);
    p_sel      = 3'(byte_idx_q - 5'd13);
    if (byte_idx_q == 5'd0)       frame_byte = ASCII_F;
    else if (byte_idx_q == 5'd1)  frame_byte = ASCII_COLON;
    else if (byte_idx_q <= 5'd9)  frame_byte = bcd_to_ascii(bcd_digit(freq_q, f_sel));
    else if (byte_idx_q == 5'd10) frame_byte = ASCII_SPACE;
    else if (byte_idx_q == 5'd11) frame_byte = ASCII_P;
    else if (byte_idx_q == 5'd12) frame_byte = ASCII_COLON;
    else if (byte_idx_q <= 5'd20) frame_byte = bcd_to_ascii(bcd_digit(peak_q, p_sel));
`ifdef UART_FRAME_CHECKSUM_EN
    else if (byte_idx_q == 5'd21) frame_byte = hex_to_ascii(csum[7:4]);
    else if (byte_idx_q == 5'd22) frame_byte = hex_to_ascii(csum[3:0]);
    else if (byte_idx_q == 5'd23) frame_byte = ASCII_CR;
`else
    else if (byte_idx_q == 5'd21) frame_byte = ASCII_CR;
`endif
    else                          frame_byte = ASCII_LF;
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .start     (ser_start),
    .data      (frame_byte),
    .tx        (ser_tx),
    .done      (ser_done),
    .near_done (ser_near_done)
  );

  assign bus.tx_pin_out = ser_tx;
  assign bus.busy       = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign bus.frame_done = (state_q == ST_DONE);
  assign bus.dropped    = dropped_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx
// Bench for uart_frame_tx at CLK_FREQ=1_000_000, BAUD=100_000 (10 clocks
// per bit). Expected line bytes go into a queue when a frame is requested;
// a UART receiver process samples mid-bit and checks each byte against it.
// Honors UART_FRAME_CHECKSUM_EN for the 25-byte line.

`timescale 1ns/1ps

module tb_uart_frame_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int FRAME_BYTES = 25;
`else
  localparam int FRAME_BYTES = 23;
`endif
  localparam int DONE_OFFSET = 2 + FRAME_BYTES * 10 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_frame_tx_if bus();

  uart_frame_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];
  int dropCount  = 0;
  int busyCount  = 0;
  int txLowCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] bcdChar(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : 8'h2D;
  endfunction

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic pushFrame(input logic [31:0] f, input logic [31:0] p);
    logic [7:0] fr[$];
    logic [7:0] x;
    fr.push_back(8'h46);
    fr.push_back(8'h3A);
    for (int i = 0; i < 8; i++) fr.push_back(bcdChar(f[31-4*i -: 4]));
    fr.push_back(8'h20);
    fr.push_back(8'h50);
    fr.push_back(8'h3A);
    for (int i = 0; i < 8; i++) fr.push_back(bcdChar(p[31-4*i -: 4]));
`ifdef UART_FRAME_CHECKSUM_EN
    x = 8'h00;
    foreach (fr[i]) x = x ^ fr[i];
    fr.push_back(hexChar(x[7:4]));
    fr.push_back(hexChar(x[3:0]));
`endif
    fr.push_back(8'h0D);
    fr.push_back(8'h0A);
    foreach (fr[i]) expQ.push_back(fr[i]);
  endtask

  // Activity counters, used to prove nothing happened over a window.
  always @(negedge clk) begin
    if (bus.dropped)     dropCount++;
    if (bus.busy)        busyCount++;
    if (!bus.tx_pin_out) txLowCount++;
  end

  // UART receiver: first low sample is half a clock into the start bit,
  // four more clocks reach mid-bit, then one bit time per sample.
  initial begin : monitor
    logic [7:0] b;
    logic       startBit;
    logic       stopBit;
    logic       ok;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx_pin_out == 1'b0) begin
        ok = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if (rst) ok = 1'b0;
        end
        startBit = bus.tx_pin_out;
        stopBit  = 1'b0;
        b        = 8'h00;
        for (int i = 0; i < 9; i++) begin
          repeat (DIV) begin
            @(negedge clk);
            if (rst) ok = 1'b0;
          end
          if (i < 8) b[i] = bus.tx_pin_out;
          else       stopBit = bus.tx_pin_out;
        end
        if (ok) begin
          checkOutput("start bit level", startBit, 1'b0);
          checkOutput("stop bit level", stopBit, 1'b1);
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected byte: actual=%0h required=none", b);
          end else begin
            want = expQ.pop_front();
            checkOutput("rx byte", b, want);
          end
        end
      end
    end
  end

  // Raises trigger in the current cycle N (caller is just past a negedge
  // with trigger low) and returns at the negedge of the frame_done cycle.
  task automatic applyStimulus(input logic [31:0] f, input logic [31:0] p,
                               input int secondEdgeAt, input int changeAt);
    int k;
    bit seen;
    int d0;
    bus.freq_bcd = f;
    bus.peak_bcd = p;
    pushFrame(f, p);
    d0 = dropCount;
    bus.trigger = 1'b1;
    @(negedge clk);
    checkOutput("busy at edge+1", bus.busy, 1'b1);
    checkOutput("line idle at edge+1", bus.tx_pin_out, 1'b1);
    @(negedge clk);
    checkOutput("start bit at edge+2", bus.tx_pin_out, 1'b0);
    bus.trigger = 1'b0;
    k = 2;
    seen = 1'b0;
    while (!seen && k < DONE_OFFSET + 50) begin
      @(negedge clk);
      k++;
      if (k == secondEdgeAt)     bus.trigger = 1'b1;
      if (k == secondEdgeAt + 3) bus.trigger = 1'b0;
      if (k == changeAt) begin
        bus.freq_bcd = 32'h5555_5555;
        bus.peak_bcd = 32'h6666_6666;
      end
      if (bus.frame_done) seen = 1'b1;
    end
    checkOutput("frame_done seen", seen, 1'b1);
    checkOutput("frame_done offset", k, DONE_OFFSET);
    checkOutput("busy low with frame_done", bus.busy, 1'b0);
    checkOutput("all bytes received", expQ.size(), 0);
    if (secondEdgeAt > 0) checkOutput("dropped pulses", dropCount - d0, 1);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    int d0;
    int b0;
    int t0;
    bus.trigger  = 1'b0;
    bus.freq_bcd = 32'h0;
    bus.peak_bcd = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset tx_pin_out", bus.tx_pin_out, 1'b1);
    checkOutput("reset busy", bus.busy, 1'b0);
    checkOutput("reset frame_done", bus.frame_done, 1'b0);
    checkOutput("reset dropped", bus.dropped, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single frame");
    applyStimulus(32'h0000_1234, 32'h0000_0987, 0, 0);
    @(negedge clk);
    checkOutput("frame_done one cycle", bus.frame_done, 1'b0);
    repeat (20) @(negedge clk);

    $display("[TB] invalid digits");
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    repeat (20) @(negedge clk);

    $display("[TB] overlap and mid-frame input change");
    applyStimulus(32'h0001_2345, 32'h0000_0042, 500, 700);
    t0 = txLowCount;
    repeat (300) @(negedge clk);
    checkOutput("no second frame", txLowCount - t0, 0);
    checkOutput("idle after overlap", bus.busy, 1'b0);

    $display("[TB] edge in frame_done cycle");
    applyStimulus(32'h0, 32'h0, 0, 0);
    d0 = dropCount;
    b0 = busyCount;
    bus.trigger = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("dropped at frame_done edge", dropCount - d0, 1);
    repeat (50) @(negedge clk);
    checkOutput("no frame from dropped edge", busyCount - b0, 0);
    bus.trigger = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] edge one cycle after frame_done");
    applyStimulus(32'h2020_0101, 32'h0000_0000, 0, 0);
    @(negedge clk);
    checkOutput("frame_done low next cycle", bus.frame_done, 1'b0);
    applyStimulus(32'h9876_5432, 32'h1000_0009, 0, 0);
    repeat (20) @(negedge clk);

    $display("[TB] reset mid-frame");
    bus.freq_bcd = 32'h1111_1111;
    bus.peak_bcd = 32'h2222_2222;
    pushFrame(32'h1111_1111, 32'h2222_2222);
    bus.trigger = 1'b1;
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset mid-frame tx", bus.tx_pin_out, 1'b1);
    checkOutput("reset mid-frame busy", bus.busy, 1'b0);
    expQ.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    b0 = busyCount;
    t0 = txLowCount;
    repeat (3000) @(negedge clk);
    checkOutput("no busy after reset", busyCount - b0, 0);
    checkOutput("line quiet after reset", txLowCount - t0, 0);
    bus.trigger = 1'b0;
    @(negedge clk);
    applyStimulus(32'h8765_4321, 32'h0000_0001, 0, 0);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
